// File: rtl/clk_div_gen.sv
// Clock-enable based divider: free-running binary taps, a programmable square
// wave with glitch-free reconfiguration at period boundaries, and a mask-selected AND.
module clk_div_gen #(
  parameter int unsigned TAPS      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_DIV = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_load,
  input  logic [TAPS:0]    cfg_mask,
  output logic [TAPS-1:0]  taps,
  output logic [TAPS-1:0]  tap_stb,
  output logic             div_out,
  output logic             div_stb,
  output logic             and_out,
  output logic             cfg_busy
);

  logic [TAPS-1:0]  tcnt;
  logic [TAPS-1:0]  tcnt_nxt;
  logic [WIDTH-1:0] pcnt;
  logic [WIDTH-1:0] act_div;
  logic [WIDTH-1:0] pend_div;
  logic [TAPS:0]    sel;
  logic             hit;
  logic             apply;
  logic             and_nxt;

  assign taps = tcnt;

  always_comb begin
    tcnt_nxt = tcnt + 1'b1;
    hit      = (pcnt == act_div);
    // Only the falling toggle ends a full period, so a new divisor never
    // shortens or stretches a half-period already in progress.
    apply    = en & hit & div_out & cfg_busy;
    sel      = {div_out, tcnt};
    and_nxt  = (|cfg_mask) & (&(sel | ~cfg_mask));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt     <= '0;
      pcnt     <= '0;
      div_out  <= 1'b0;
      tap_stb  <= '0;
      div_stb  <= 1'b0;
      and_out  <= 1'b0;
      act_div  <= WIDTH'(RESET_DIV);
      pend_div <= '0;
      cfg_busy <= 1'b0;
    end else begin
      tap_stb <= '0;
      div_stb <= 1'b0;
      if (en) begin
        tcnt    <= tcnt_nxt;
        tap_stb <= tcnt_nxt & ~tcnt;
        if (hit) begin
          pcnt    <= '0;
          div_out <= ~div_out;
          div_stb <= ~div_out;
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end
      if (apply) act_div <= pend_div;
      // A load in the apply cycle queues behind the value being applied.
      if (cfg_load) begin
        pend_div <= cfg_div;
        cfg_busy <= 1'b1;
      end else if (apply) begin
        cfg_busy <= 1'b0;
      end
      and_out <= and_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: table vectors, directed corner
// sequences and a randomized run, all scored against a queue of expected results.
module tb_clk_div_gen;
  localparam int unsigned TAPS      = 4;
  localparam int unsigned WIDTH     = 4;
  localparam int unsigned RESET_DIV = 0;

  logic             clk = 1'b0;
  logic             reset, en, cfg_load;
  logic [WIDTH-1:0] cfg_div;
  logic [TAPS:0]    cfg_mask;
  logic [TAPS-1:0]  taps, tap_stb;
  logic             div_out, div_stb, and_out, cfg_busy;

  clk_div_gen #(.TAPS(TAPS), .WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_div(cfg_div), .cfg_load(cfg_load),
    .cfg_mask(cfg_mask), .taps(taps), .tap_stb(tap_stb), .div_out(div_out),
    .div_stb(div_stb), .and_out(and_out), .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAPS-1:0] t;
    logic [TAPS-1:0] ts;
    logic            d;
    logic            ds;
    logic            b;
    logic            a;
  } exp_t;

  typedef struct {
    logic             rst, en, load;
    logic [WIDTH-1:0] dv;
    logic [TAPS:0]    mask;
    exp_t             e;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference: enabled-cycle count for taps, countdown to next toggle for div_out.
  int unsigned     m_ecnt, m_rem;
  logic [WIDTH-1:0] m_act, m_pend;
  logic            m_busy, m_div, m_ao, m_dstb;
  logic [TAPS-1:0] m_tstb;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic ena, input logic load,
                            input logic [WIDTH-1:0] dv, input logic [TAPS:0] mask,
                            output exp_t e);
    logic [TAPS:0]   src;
    logic [TAPS-1:0] old_t;
    logic            apply, toggled;
    src = {m_div, TAPS'(m_ecnt)};
    if (rst) begin
      m_ecnt = 0; m_act = WIDTH'(RESET_DIV); m_rem = RESET_DIV; m_pend = '0;
      m_busy = 0; m_div = 0; m_ao = 0; m_tstb = '0; m_dstb = 0;
    end else begin
      m_ao = (mask != '0) && ((src & mask) == mask);
      m_tstb = '0; m_dstb = 0; apply = 0; toggled = 0;
      if (ena) begin
        old_t  = TAPS'(m_ecnt);
        m_ecnt = m_ecnt + 1;
        m_tstb = TAPS'(m_ecnt) & ~old_t;
        if (m_rem == 0) begin
          toggled = 1;
          m_dstb  = !m_div;
          apply   = m_div && m_busy;
          m_div   = !m_div;
        end else begin
          m_rem = m_rem - 1;
        end
      end
      if (apply) m_act = m_pend;
      if (toggled) m_rem = m_act;
      if (load) begin m_pend = dv; m_busy = 1; end
      else if (apply) m_busy = 0;
    end
    e = '{t: TAPS'(m_ecnt), ts: m_tstb, d: m_div, ds: m_dstb, b: m_busy, a: m_ao};
  endtask

  task automatic cycle_x(input logic rst, input logic ena, input logic load,
                         input logic [WIDTH-1:0] dv, input logic [TAPS:0] mask,
                         input bit use_tbl, input exp_t texp);
    exp_t e, got;
    reset = rst; en = ena; cfg_load = load; cfg_div = dv; cfg_mask = mask;
    model_step(rst, ena, load, dv, mask, e);
    sb.push_back(use_tbl ? texp : e);
    @(posedge clk); #1;
    got = {taps, tap_stb, div_out, div_stb, cfg_busy, and_out};
    e = sb.pop_front();
    chk("taps",    got.t,  e.t);
    chk("tap_stb", got.ts, e.ts);
    chk("div_out", got.d,  e.d);
    chk("div_stb", got.ds, e.ds);
    chk("busy",    got.b,  e.b);
    chk("and_out", got.a,  e.a);
  endtask

  task automatic cycle(input logic rst, input logic ena, input logic load,
                       input logic [WIDTH-1:0] dv, input logic [TAPS:0] mask);
    cycle_x(rst, ena, load, dv, mask, 1'b0, '0);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (cfg_busy && n < 40) begin cycle(0, 1, 0, '0, '0); n++; end
    chk("apply_timeout", cfg_busy, 1'b0);
  endtask

  function automatic vec_t mkv(input logic rst, input logic ena, input logic load,
                               input logic [WIDTH-1:0] dv, input logic [TAPS:0] mask,
                               input logic [TAPS-1:0] t, input logic [TAPS-1:0] ts,
                               input logic d, input logic ds, input logic b, input logic a);
    vec_t v;
    v.rst = rst; v.en = ena; v.load = load; v.dv = dv; v.mask = mask;
    v.e = '{t: t, ts: ts, d: d, ds: ds, b: b, a: a};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[8];
    logic [31:0] pat;
    int          cnt, first, per;
    logic        r_rst, r_en, r_ld;
    logic [WIDTH-1:0] r_dv;
    logic [TAPS:0]    r_mask;

    //            rst en ld dv    mask      taps  stb   d  ds b  a
    tbl[0] = mkv(1, 0, 0, 4'd0, 5'b00000, 4'd0, 4'h0, 0, 0, 0, 0);
    tbl[1] = mkv(0, 1, 0, 4'd0, 5'b00000, 4'd1, 4'h1, 1, 1, 0, 0);
    tbl[2] = mkv(0, 1, 0, 4'd0, 5'b00001, 4'd2, 4'h2, 0, 0, 0, 1);
    tbl[3] = mkv(0, 1, 0, 4'd0, 5'b00001, 4'd3, 4'h1, 1, 1, 0, 0);
    tbl[4] = mkv(0, 0, 0, 4'd0, 5'b10000, 4'd3, 4'h0, 1, 0, 0, 1);
    tbl[5] = mkv(0, 0, 1, 4'd3, 5'b10001, 4'd3, 4'h0, 1, 0, 1, 1);
    tbl[6] = mkv(0, 1, 0, 4'd0, 5'b00000, 4'd4, 4'h4, 0, 0, 0, 0);
    tbl[7] = mkv(0, 1, 0, 4'd0, 5'b00000, 4'd5, 4'h1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      cycle_x(tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].dv, tbl[i].mask, 1'b1, tbl[i].e);

    // Tap strobes over 32 enabled cycles after reset.
    cycle(1, 0, 0, '0, '0);
    pat = '0;
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, 0, '0, '0);
      pat[i] = tap_stb[3];
    end
    chk("tap3_stb_cycles", pat, 32'h0080_0080);

    // D=2 applied at the next falling toggle: 3 low, 3 high, no runt.
    cycle(1, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0, '0);
    cycle(0, 1, 1, 4'd2, '0);
    chk("busy_after_load", cfg_busy, 1'b1);
    wait_idle();
    pat = {31'd0, div_out};
    for (int i = 0; i < 11; i++) begin cycle(0, 1, 0, '0, '0); pat = {pat[30:0], div_out}; end
    chk("d2_wave", pat, 32'b000111000111);

    // Last load wins: D=5 then D=1 before the boundary.
    cycle(1, 0, 0, '0, '0);
    cycle(0, 0, 1, 4'd5, '0);
    cycle(0, 0, 1, 4'd1, '0);
    wait_idle();
    pat = {31'd0, div_out};
    for (int i = 0; i < 7; i++) begin cycle(0, 1, 0, '0, '0); pat = {pat[30:0], div_out}; end
    chk("last_load_wave", pat, 32'b00110011);

    // AND of taps[1:0], then an empty mask.
    cnt = 0;
    for (int i = 0; i < 16; i++) begin cycle(0, 1, 0, '0, 5'b00011); cnt += int'(and_out); end
    chk("and_mask3_count", cnt, 4);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin cycle(0, 1, 0, '0, 5'b00000); cnt += int'(and_out); end
    chk("and_mask0_count", cnt, 0);

    // Freeze mid-period with D=3, then resume.
    cycle(1, 0, 0, '0, '0);
    cycle(0, 0, 1, 4'd3, '0);
    wait_idle();
    cycle(0, 1, 0, '0, 5'b11111);
    cycle(0, 1, 0, '0, 5'b11111);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, 5'b10011);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0, 5'b10000);

    // Reset while a value is pending and pcnt==2.
    cycle(1, 0, 0, '0, '0);
    cycle(0, 0, 1, 4'd3, '0);
    wait_idle();
    cycle(0, 1, 1, 4'd7, '0);
    cycle(0, 1, 0, '0, '0);
    cycle(1, 1, 1, 4'd9, 5'b11111);
    chk("busy_cleared_by_reset", cfg_busy, 1'b0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, '0, '0);

    // Largest divisor: period 2^(WIDTH+1).
    cycle(1, 0, 0, '0, '0);
    cycle(0, 0, 1, 4'd15, '0);
    wait_idle();
    first = -1; per = 0;
    for (int i = 0; i < 80 && per == 0; i++) begin
      cycle(0, 1, 0, '0, '0);
      if (div_stb) begin
        if (first < 0) first = i;
        else per = i - first;
      end
    end
    chk("period_d15", per, 32);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r_rst  = ($urandom_range(63) == 0);
      r_en   = ($urandom_range(3) != 0);
      r_ld   = ($urandom_range(7) == 0);
      r_dv   = WIDTH'($urandom_range(3));
      r_mask = (TAPS + 1)'($urandom);
      cycle(r_rst, r_en, r_ld, r_dv, r_mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
